matrix_mem_seq: RTL and testbench
=================================

MATRIX_MEM_SEQ -- requirements
Module: matrix_mem_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state updates SHALL occur on the rising edge of clk.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mat_start  in  1  request to run one matrix memory op; accepted only when mat_ready=1
- mat_op  in  3  op code: 001 row load (4 beats), 011 row store (4 beats), 100 full-matrix load (16 beats)
- mat_base  in  32  base byte address
- mat_wdata  in  128  row store data; beat k uses bits [32k+31:32k]
- sc_req  in  1  scalar MEM-stage access request
- sc_we  in  1  scalar write enable
- sc_addr  in  32  scalar address
- sc_wdata  in  32  scalar write data
- dmem_en  out  1  data-memory access enable
- dmem_we  out  1  data-memory write enable
- dmem_addr  out  32  data-memory address
- dmem_wdata  out  32  data-memory write data
- dmem_rdata  in  32  read data, valid one cycle after a read issue
- sc_grant  out  1  scalar access owns the port this cycle
- pipe_stall  out  1  scalar access blocked; the pipeline holds
- mat_ready  out  1  block is idle
- mat_rvalid  out  1  matrix read beat valid
- mat_ridx  out  4  beat index of mat_rdata
- mat_rdata  out  32  matrix read data
- mat_done  out  1  one-cycle completion pulse
- mat_err  out  1  one-cycle illegal-op pulse

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE, FIN.
REQ-004 In IDLE:
- mat_ready=1.
- The port is owned by the scalar side: dmem_en=sc_req, dmem_we=sc_req&sc_we, dmem_addr=sc_addr, dmem_wdata=sc_wdata, sc_grant=sc_req.
REQ-005 On mat_start=1 in IDLE with a legal mat_op, the block SHALL:
- latch mat_op, mat_base with bits [1:0] forced to 00, and mat_wdata;
- clear the beat counter;
- enter ISSUE next cycle.
A scalar request in that same cycle SHALL still be granted.
REQ-006 On mat_start=1 in IDLE with an illegal mat_op, the block SHALL stay in IDLE, issue no access, and pulse mat_err for exactly one cycle, in the following cycle.
REQ-007 In ISSUE:
- dmem_en=1;
- dmem_addr = latched base + 4*cnt, modulo 2^32 (wrap-around permitted);
- dmem_we=1 only for op 011, with dmem_wdata equal to word cnt of the latched data;
- cnt SHALL increment each cycle.
REQ-008 ISSUE SHALL last exactly N cycles (N=4 for ops 001/011, N=16 for op 100), then go to FIN.
REQ-009 FIN SHALL last one cycle, with dmem_en=0 and mat_done=1, then return to IDLE.
REQ-010 For load ops, read data returns one cycle after issue. In the cycle after beat k is issued, the block SHALL drive:
- mat_rvalid=1
- mat_ridx=k
- mat_rdata=dmem_rdata
The last beat's rvalid therefore coincides with FIN.
REQ-011 For store ops, mat_rvalid SHALL remain 0.
REQ-012 In ISSUE and FIN:
- sc_grant=0, mat_ready=0;
- pipe_stall=sc_req;
- mat_start SHALL be ignored.
In IDLE, pipe_stall=0.
REQ-013 Latency SHALL be: start accepted at T, beats issued T+1..T+N, mat_done at T+N+1, next start accepted at T+N+2 at the earliest.
REQ-014 Changes on mat_base, mat_op or mat_wdata after acceptance SHALL NOT affect the running op.

Reset
REQ-015 On a clock edge with rst=1, the block SHALL enter IDLE from any state, clear cnt and all latched op state, and discard any pending read beat.
REQ-016 After reset, these outputs SHALL be 0: dmem_en, dmem_we, mat_rvalid, mat_ridx, mat_rdata, mat_done, mat_err, pipe_stall, sc_grant. mat_ready SHALL be 1. dmem_addr and dmem_wdata SHALL follow the scalar inputs.
REQ-017 If reset is asserted mid-ISSUE, no further dmem_en and no mat_done SHALL follow.

Verification
REQ-018 Row load: mat_start, op=001, base=0x1000 -> reads at 0x1000/4/8/C over 4 cycles; mat_rvalid with ridx 0..3 one cycle later each; mat_done at T+5.
REQ-019 Row store: op=011, base=0x2003, wdata=0x4444_4444_3333_3333_2222_2222_1111_1111 -> writes 0x11111111@0x2000 through 0x44444444@0x200C; mat_rvalid never high.
REQ-020 Full-matrix load: op=100, base=0xFFFFFFF8 -> 16 reads with addresses wrapping to 0x00000000 at beat 2; ridx 0..15; mat_done at T+17.
REQ-021 Contention: sc_req held high while mat_start (op=001) is accepted -> sc_grant=1 at T; sc_grant=0 and pipe_stall=1 for T+1..T+5; sc_grant=1 at T+6.
REQ-022 Illegal op=010 -> mat_err pulses once at T+1; dmem_en stays 0; mat_ready stays 1.
REQ-023 rst=1 at the 2nd ISSUE cycle of op=100 -> IDLE next cycle; dmem_en, mat_rvalid and mat_done all 0 afterwards.

Source files
------------

// File: rtl/matrix_mem_seq.sv
// matrix_mem_seq: sequences row / full-matrix loads and stores onto a single
// 32-bit data-memory port that is otherwise owned by the scalar MEM stage.
// While a matrix op runs, scalar requests are refused and the pipeline stalls.
module matrix_mem_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         mat_start,
    input  logic [2:0]   mat_op,
    input  logic [31:0]  mat_base,
    input  logic [127:0] mat_wdata,
    input  logic         sc_req,
    input  logic         sc_we,
    input  logic [31:0]  sc_addr,
    input  logic [31:0]  sc_wdata,
    output logic         dmem_en,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    input  logic [31:0]  dmem_rdata,
    output logic         sc_grant,
    output logic         pipe_stall,
    output logic         mat_ready,
    output logic         mat_rvalid,
    output logic [3:0]   mat_ridx,
    output logic [31:0]  mat_rdata,
    output logic         mat_done,
    output logic         mat_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;

    localparam logic [2:0] OP_ROW_LD = 3'b001;
    localparam logic [2:0] OP_ROW_ST = 3'b011;
    localparam logic [2:0] OP_MAT_LD = 3'b100;

    logic [1:0]   state;
    logic [2:0]   op_q;
    logic [31:0]  base_q;
    logic [127:0] wdata_q;
    logic [3:0]   cnt;
    logic         rd_pend;
    logic [3:0]   rd_idx;
    logic         err_q;

    logic         op_legal;
    logic         is_store;
    logic         last_beat;

    assign op_legal  = (mat_op == OP_ROW_LD) || (mat_op == OP_ROW_ST) || (mat_op == OP_MAT_LD);
    assign is_store  = (op_q == OP_ROW_ST);
    // Full-matrix load runs 16 beats, row ops run 4.
    assign last_beat = (op_q == OP_MAT_LD) ? (cnt == 4'd15) : (cnt == 4'd3);

    // State, latched op context, beat counter and the one-deep read-return tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
            err_q   <= 1'b0;
        end else begin
            // A load beat issued this cycle returns data next cycle.
            rd_pend <= (state == S_ISSUE) && !is_store;
            rd_idx  <= ((state == S_ISSUE) && !is_store) ? cnt : 4'd0;
            err_q   <= (state == S_IDLE) && mat_start && !op_legal;
            case (state)
                S_IDLE: begin
                    if (mat_start && op_legal) begin
                        op_q    <= mat_op;
                        base_q  <= {mat_base[31:2], 2'b00};
                        wdata_q <= mat_wdata;
                        cnt     <= '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt <= cnt + 4'd1;
                    if (last_beat) state <= S_FIN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port mux: scalar side owns the port in IDLE, sequencer owns it otherwise.
    always_comb begin
        dmem_en    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = sc_addr;
        dmem_wdata = sc_wdata;
        sc_grant   = 1'b0;
        pipe_stall = 1'b0;
        mat_ready  = 1'b0;
        mat_done   = 1'b0;
        case (state)
            S_IDLE: begin
                mat_ready = 1'b1;
                dmem_en   = sc_req;
                dmem_we   = sc_req & sc_we;
                sc_grant  = sc_req;
            end
            S_ISSUE: begin
                pipe_stall = sc_req;
                dmem_en    = 1'b1;
                dmem_we    = is_store;
                dmem_addr  = base_q + {26'd0, cnt, 2'b00};
                dmem_wdata = wdata_q[{cnt[1:0], 5'd0} +: 32];
            end
            default: begin
                pipe_stall = sc_req;
                mat_done   = 1'b1;
            end
        endcase
    end

    assign mat_rvalid = rd_pend;
    assign mat_ridx   = rd_idx;
    assign mat_rdata  = rd_pend ? dmem_rdata : 32'd0;
    assign mat_err    = err_q;

endmodule

// File: tb/tb_matrix_mem_seq.sv
// Directed bench for matrix_mem_seq: inputs driven on the falling edge,
// outputs checked 1ns later, a small read-data memory model on the rising edge.
module tb_matrix_mem_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         mat_start;
    logic [2:0]   mat_op;
    logic [31:0]  mat_base;
    logic [127:0] mat_wdata;
    logic         sc_req;
    logic         sc_we;
    logic [31:0]  sc_addr;
    logic [31:0]  sc_wdata;
    logic         dmem_en;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic [31:0]  dmem_rdata;
    logic         sc_grant;
    logic         pipe_stall;
    logic         mat_ready;
    logic         mat_rvalid;
    logic [3:0]   mat_ridx;
    logic [31:0]  mat_rdata;
    logic         mat_done;
    logic         mat_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_mem_seq dut (
        .clk(clk), .rst(rst), .mat_start(mat_start), .mat_op(mat_op),
        .mat_base(mat_base), .mat_wdata(mat_wdata), .sc_req(sc_req),
        .sc_we(sc_we), .sc_addr(sc_addr), .sc_wdata(sc_wdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .sc_grant(sc_grant),
        .pipe_stall(pipe_stall), .mat_ready(mat_ready), .mat_rvalid(mat_rvalid),
        .mat_ridx(mat_ridx), .mat_rdata(mat_rdata), .mat_done(mat_done),
        .mat_err(mat_err)
    );

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Read data appears one cycle after a read issue.
    always @(posedge clk) begin
        if (dmem_en && !dmem_we) dmem_rdata <= mem_f(dmem_addr);
        else                     dmem_rdata <= 32'h0BAD_0BAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one legal op; scrambles op/base/wdata and holds mat_start during the op.
    task automatic run_op(input logic [2:0] op, input logic [31:0] base,
                          input logic [127:0] wd, input logic sc, input string nm);
        int n;
        logic ld;
        logic [31:0] b;
        n  = (op == 3'b100) ? 16 : 4;
        ld = (op != 3'b011);
        b  = {base[31:2], 2'b00};
        @(negedge clk);
        mat_start = 1'b1; mat_op = op; mat_base = base; mat_wdata = wd;
        sc_req = sc; sc_we = 1'b0; sc_addr = 32'h0000_0ABC;
        #1;
        chk({nm, " T ready"}, mat_ready, 1);
        chk({nm, " T grant"}, sc_grant, sc);
        chk({nm, " T en"}, dmem_en, sc);
        chk({nm, " T stall"}, pipe_stall, 0);
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            mat_start = (i <= n);
            mat_op    = (op == 3'b100) ? 3'b001 : 3'b100;
            mat_base  = 32'hDEAD_BEE0;
            mat_wdata = ~wd;
            #1;
            chk($sformatf("%s T+%0d ready", nm, i), mat_ready, 0);
            chk($sformatf("%s T+%0d grant", nm, i), sc_grant, 0);
            chk($sformatf("%s T+%0d stall", nm, i), pipe_stall, sc);
            chk($sformatf("%s T+%0d en", nm, i), dmem_en, (i <= n));
            chk($sformatf("%s T+%0d done", nm, i), mat_done, (i == n + 1));
            if (i <= n) begin
                chk($sformatf("%s T+%0d addr", nm, i), dmem_addr, b + 32'(4 * (i - 1)));
                chk($sformatf("%s T+%0d we", nm, i), dmem_we, !ld);
                if (!ld) chk($sformatf("%s T+%0d wdata", nm, i), dmem_wdata, wd[32*(i-1) +: 32]);
            end
            chk($sformatf("%s T+%0d rvalid", nm, i), mat_rvalid, ld && (i >= 2));
            if (ld && i >= 2) begin
                chk($sformatf("%s T+%0d ridx", nm, i), mat_ridx, i - 2);
                chk($sformatf("%s T+%0d rdata", nm, i), mat_rdata, mem_f(b + 32'(4 * (i - 2))));
            end
        end
        @(negedge clk);
        mat_start = 1'b0;
        #1;
        chk({nm, " end ready"}, mat_ready, 1);
        chk({nm, " end grant"}, sc_grant, sc);
        chk({nm, " end stall"}, pipe_stall, 0);
        chk({nm, " end done"}, mat_done, 0);
        chk({nm, " end rvalid"}, mat_rvalid, 0);
        sc_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mat_start = 1'b0; mat_op = 3'b000; mat_base = '0; mat_wdata = '0;
        sc_req = 1'b0; sc_we = 1'b0; sc_addr = 32'h1234_5678; sc_wdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        chk("rst en", dmem_en, 0);
        chk("rst we", dmem_we, 0);
        chk("rst rvalid", mat_rvalid, 0);
        chk("rst ridx", mat_ridx, 0);
        chk("rst rdata", mat_rdata, 0);
        chk("rst done", mat_done, 0);
        chk("rst err", mat_err, 0);
        chk("rst stall", pipe_stall, 0);
        chk("rst grant", sc_grant, 0);
        chk("rst ready", mat_ready, 1);
        chk("rst addr", dmem_addr, 32'h1234_5678);
        chk("rst wdata", dmem_wdata, 32'hCAFE_F00D);
        @(negedge clk);
        rst = 1'b0;

        // Scalar write passes straight through in IDLE.
        @(negedge clk);
        sc_req = 1'b1; sc_we = 1'b1; sc_addr = 32'h0000_0040; sc_wdata = 32'h5555_AAAA;
        #1;
        chk("scalar en", dmem_en, 1);
        chk("scalar we", dmem_we, 1);
        chk("scalar addr", dmem_addr, 32'h0000_0040);
        chk("scalar wdata", dmem_wdata, 32'h5555_AAAA);
        chk("scalar grant", sc_grant, 1);
        sc_req = 1'b0; sc_we = 1'b0;

        run_op(3'b001, 32'h0000_1000, 128'h0, 1'b0, "rowld");
        run_op(3'b011, 32'h0000_2003,
               128'h4444_4444_3333_3333_2222_2222_1111_1111, 1'b0, "rowst");
        run_op(3'b100, 32'hFFFF_FFF8, 128'h0, 1'b0, "matld");
        run_op(3'b001, 32'h0000_3000, 128'h0, 1'b1, "contend");

        // Illegal op: one mat_err pulse, no access, stays ready.
        @(negedge clk);
        mat_start = 1'b1; mat_op = 3'b010; mat_base = 32'h0000_4000;
        #1;
        chk("ill T err", mat_err, 0);
        chk("ill T en", dmem_en, 0);
        @(negedge clk);
        mat_start = 1'b0;
        #1;
        chk("ill T+1 err", mat_err, 1);
        chk("ill T+1 en", dmem_en, 0);
        chk("ill T+1 ready", mat_ready, 1);
        @(negedge clk);
        #1;
        chk("ill T+2 err", mat_err, 0);
        chk("ill T+2 en", dmem_en, 0);
        chk("ill T+2 ready", mat_ready, 1);

        // Reset during the 2nd ISSUE cycle of a full-matrix load.
        @(negedge clk);
        mat_start = 1'b1; mat_op = 3'b100; mat_base = 32'h0000_5000;
        @(negedge clk);
        mat_start = 1'b0;
        #1;
        chk("rstmid T+1 en", dmem_en, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid T+2 addr", dmem_addr, 32'h0000_5004);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid ready", mat_ready, 1);
        chk("rstmid ridx", mat_ridx, 0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("rstmid +%0d en", i), dmem_en, 0);
            chk($sformatf("rstmid +%0d rvalid", i), mat_rvalid, 0);
            chk($sformatf("rstmid +%0d done", i), mat_done, 0);
            @(negedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
